// File: rtl/fpu_add_sub_arbiter.sv
// Round-robin front end for a single shared, pipelined FP32 add/sub unit.
// Requesters hand over operands through a one-hot valid/ready grant; the
// requester ID rides a tag pipe that matches the FPU latency, so each result
// and its rounding-overflow flag go back to the requester that issued it.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no grants; o_idle is high once nothing is in flight
//   RUN   | one round-robin grant per cycle while i_en is high
//   DRAIN | no grants; in-flight operations finish, then back to IDLE
module fpu_add_sub_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int SIZE_DATA   = 32,
    parameter int FPU_LATENCY = 3
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_en,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    output logic [NUM_REQ-1:0]             o_req_ready,
    input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_a,
    input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_b,
    input  logic [NUM_REQ-1:0]             i_req_sub,
    output logic                           o_fpu_valid,
    output logic [SIZE_DATA-1:0]           o_fpu_a,
    output logic [SIZE_DATA-1:0]           o_fpu_b,
    output logic                           o_fpu_sub,
    input  logic [SIZE_DATA-1:0]           i_fpu_result,
    input  logic                           i_fpu_ov_flow,
    output logic [NUM_REQ-1:0]             o_rsp_valid,
    output logic [SIZE_DATA-1:0]           o_rsp_data,
    output logic                           o_rsp_ov_flow,
    output logic                           o_idle
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [ID_W-1:0]                 rr_ptr_q, rr_ptr_d;

    logic                            fpu_valid_q, fpu_valid_d;
    logic [SIZE_DATA-1:0]            fpu_a_q, fpu_a_d;
    logic [SIZE_DATA-1:0]            fpu_b_q, fpu_b_d;
    logic                            fpu_sub_q, fpu_sub_d;
    logic [ID_W-1:0]                 fpu_id_q, fpu_id_d;

    logic [FPU_LATENCY-1:0]          tag_vld_q, tag_vld_d;
    logic [FPU_LATENCY-1:0][ID_W-1:0] tag_id_q, tag_id_d;

    logic [NUM_REQ-1:0]              rsp_valid_q, rsp_valid_d;
    logic [SIZE_DATA-1:0]            rsp_data_q, rsp_data_d;
    logic                            rsp_ov_q, rsp_ov_d;

    logic                            win_found;
    logic [ID_W-1:0]                 win_id;
    logic [NUM_REQ-1:0]              req_ready;
    logic                            xfer;
    logic                            tail_vld;
    logic [ID_W-1:0]                 tail_id;
    logic                            pipe_empty;
    logic                            drain_done;

    // Round-robin search: first valid requester at or above the pointer, with wrap.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!win_found && i_req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // One-hot grant, only while running; depends on valid and pointer, never on ready.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_RUN && win_found) begin
            req_ready = ONE_HOT_0 << win_id;
        end
        xfer = |req_ready;
    end

    // Issue stage and pointer advance; data outputs hold when nothing is issued.
    always_comb begin
        fpu_valid_d = xfer;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        fpu_sub_d   = fpu_sub_q;
        fpu_id_d    = fpu_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            fpu_a_d   = i_req_a[int'(win_id)*SIZE_DATA +: SIZE_DATA];
            fpu_b_d   = i_req_b[int'(win_id)*SIZE_DATA +: SIZE_DATA];
            fpu_sub_d = i_req_sub[win_id];
            fpu_id_d  = win_id;
            rr_ptr_d  = (int'(win_id) == NUM_REQ-1) ? '0 : win_id + 1'b1;
        end
    end

    // Tag pipe fed from the issue register, so its tail lines up with i_fpu_result.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = fpu_valid_q;
        tag_id_d[0]  = fpu_id_q;
        for (int k = 1; k < FPU_LATENCY; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end
    end

    // Response stage: steer the FPU result to the owner recorded in the tail tag.
    always_comb begin
        tail_vld    = tag_vld_q[FPU_LATENCY-1];
        tail_id     = tag_id_q[FPU_LATENCY-1];
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_ov_d    = 1'b0;
        if (tail_vld) begin
            rsp_valid_d = ONE_HOT_0 << tail_id;
            rsp_data_d  = i_fpu_result;
            rsp_ov_d    = i_fpu_ov_flow;
        end
    end

    // Emptiness: drain_done looks one stage ahead because a response in the
    // output register clears on the same edge that the FSM moves to IDLE,
    // which lets o_idle rise the cycle right after the last response.
    always_comb begin
        pipe_empty = ~|tag_vld_q & ~fpu_valid_q & ~|rsp_valid_q;
        drain_done = ~|tag_vld_q & ~fpu_valid_q;
    end

    // Control FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!i_en) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (i_en)            state_d = ST_RUN;
                else if (drain_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pointer, issue, tag and response registers; reset drops in-flight tags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            fpu_valid_q <= 1'b0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_sub_q   <= 1'b0;
            fpu_id_q    <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_ov_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            fpu_valid_q <= fpu_valid_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            fpu_sub_q   <= fpu_sub_d;
            fpu_id_q    <= fpu_id_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ov_q    <= rsp_ov_d;
        end
    end

    assign o_req_ready   = req_ready;
    assign o_fpu_valid   = fpu_valid_q;
    assign o_fpu_a       = fpu_a_q;
    assign o_fpu_b       = fpu_b_q;
    assign o_fpu_sub     = fpu_sub_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_data    = rsp_data_q;
    assign o_rsp_ov_flow = rsp_ov_q;
    assign o_idle        = (state_q == ST_IDLE) & pipe_empty;

endmodule

// File: tb/tb_fpu_add_sub_arbiter.sv
// Scoreboard bench for fpu_add_sub_arbiter. Operands are small integers
// encoded as FP32 so the add/sub reference is exact integer arithmetic.
module tb_fpu_add_sub_arbiter;

    localparam int N  = 4;
    localparam int SD = 32;
    localparam int L  = 3;

    logic              clk;
    logic              rst_n;
    logic              i_en;
    logic [N-1:0]      i_req_valid;
    logic [N-1:0]      o_req_ready;
    logic [N*SD-1:0]   i_req_a;
    logic [N*SD-1:0]   i_req_b;
    logic [N-1:0]      i_req_sub;
    logic              o_fpu_valid;
    logic [SD-1:0]     o_fpu_a;
    logic [SD-1:0]     o_fpu_b;
    logic              o_fpu_sub;
    logic [SD-1:0]     i_fpu_result;
    logic              i_fpu_ov_flow;
    logic [N-1:0]      o_rsp_valid;
    logic [SD-1:0]     o_rsp_data;
    logic              o_rsp_ov_flow;
    logic              o_idle;

    fpu_add_sub_arbiter #(.NUM_REQ(N), .SIZE_DATA(SD), .FPU_LATENCY(L)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(i_en),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_sub(i_req_sub),
        .o_fpu_valid(o_fpu_valid), .o_fpu_a(o_fpu_a), .o_fpu_b(o_fpu_b), .o_fpu_sub(o_fpu_sub),
        .i_fpu_result(i_fpu_result), .i_fpu_ov_flow(i_fpu_ov_flow),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_ov_flow(o_rsp_ov_flow),
        .o_idle(o_idle)
    );

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        ov;
        int          cyc;
    } item_t;

    item_t issue_q[$];
    item_t rsp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int   a_int[N];
    int   b_int[N];
    logic [N-1:0] sub_v;
    logic prev_en;
    int   ptr_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] int_to_fp32(input int v);
        logic [31:0] r;
        int m;
        int p;
        r = '0;
        if (v == 0) return r;
        m = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 31; i++) if ((m >> i) != 0) p = i;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'(m << (23 - p));
        return r;
    endfunction

    function automatic int fp32_to_int(input logic [31:0] f);
        int e;
        int m;
        if (f[30:0] == 31'd0) return 0;
        e = int'(f[30:23]) - 127;
        m = int'({1'b1, f[22:0]}) >> (23 - e);
        return f[31] ? -m : m;
    endfunction

    // Rounding-overflow rule shared by the FPU model and the expectations.
    function automatic logic ov_rule(input int a);
        return (a % 5) == 0;
    endfunction

    // Behavioural FPU: fixed latency L, result computed from the issued operands.
    logic        pv [L];
    logic [31:0] pa [L];
    logic [31:0] pb [L];
    logic        ps [L];
    initial for (int k = 0; k < L; k++) begin pv[k] = 1'b0; pa[k] = '0; pb[k] = '0; ps[k] = 1'b0; end

    always @(negedge clk) begin
        int ai;
        int bi;
        ai = fp32_to_int(pa[L-1]);
        bi = fp32_to_int(pb[L-1]);
        if (pv[L-1]) begin
            i_fpu_result  = int_to_fp32(ps[L-1] ? ai - bi : ai + bi);
            i_fpu_ov_flow = ov_rule(ai);
        end else begin
            i_fpu_result  = $urandom;
            i_fpu_ov_flow = 1'($urandom_range(0, 1));
        end
        for (int k = L-1; k > 0; k--) begin
            pv[k] = pv[k-1]; pa[k] = pa[k-1]; pb[k] = pb[k-1]; ps[k] = ps[k-1];
        end
        pv[0] = o_fpu_valid; pa[0] = o_fpu_a; pb[0] = o_fpu_b; ps[0] = o_fpu_sub;
    end

    // Monitor: pops expectations whenever the DUT presents an issue or a response.
    always @(negedge clk) begin
        item_t it;
        if (o_fpu_valid) begin
            total++;
            if (issue_q.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected cyc=%0d a=%h", cyc, o_fpu_a);
            end else begin
                it = issue_q.pop_front();
                if (o_fpu_a !== it.a || o_fpu_b !== it.b || o_fpu_sub !== it.sub || cyc != it.cyc + 1) begin
                    bad++;
                    $display("FAIL issue cyc=%0d got a=%h b=%h sub=%b want a=%h b=%h sub=%b at cyc %0d",
                             cyc, o_fpu_a, o_fpu_b, o_fpu_sub, it.a, it.b, it.sub, it.cyc + 1);
                end
            end
        end else if (issue_q.size() != 0 && cyc > issue_q[0].cyc + 1) begin
            total++; bad++;
            it = issue_q.pop_front();
            $display("FAIL issue_missing cyc=%0d want id=%0d due cyc %0d", cyc, it.id, it.cyc + 1);
        end

        if (o_rsp_valid != '0) begin
            total++;
            if (rsp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected cyc=%0d valid=%b data=%h", cyc, o_rsp_valid, o_rsp_data);
            end else begin
                it = rsp_q.pop_front();
                if (o_rsp_valid !== (4'b0001 << it.id) || o_rsp_data !== it.res ||
                    o_rsp_ov_flow !== it.ov || cyc != it.cyc + L + 2) begin
                    bad++;
                    $display("FAIL rsp cyc=%0d got valid=%b data=%h ov=%b want valid=%b data=%h ov=%b at cyc %0d",
                             cyc, o_rsp_valid, o_rsp_data, o_rsp_ov_flow, 4'b0001 << it.id,
                             it.res, it.ov, it.cyc + L + 2);
                end
            end
        end else begin
            total++;
            if (o_rsp_ov_flow !== 1'b0) begin
                bad++;
                $display("FAIL ov_without_valid cyc=%0d got ov=%b want 0", cyc, o_rsp_ov_flow);
            end
            if (rsp_q.size() != 0 && cyc > rsp_q[0].cyc + L + 2) begin
                total++; bad++;
                it = rsp_q.pop_front();
                $display("FAIL rsp_missing cyc=%0d want id=%0d due cyc %0d", cyc, it.id, it.cyc + L + 2);
            end
        end
    end

    // Reference arbiter: grants only if i_en was high last cycle, round-robin from ptr_m.
    function automatic logic [N-1:0] predict(input logic [N-1:0] v);
        int k;
        if (!prev_en) return '0;
        for (int i = 0; i < N; i++) begin
            k = (ptr_m + i) % N;
            if (v[k]) return 4'b0001 << k;
        end
        return '0;
    endfunction

    // One cycle of stimulus, driven at the negedge; grant is checked against the model.
    task automatic step(input logic en, input logic [N-1:0] vld);
        logic [N-1:0] exp_rdy;
        item_t it;
        int w;
        i_en        = en;
        i_req_valid = vld;
        for (int k = 0; k < N; k++) begin
            i_req_a[k*SD +: SD] = int_to_fp32(a_int[k]);
            i_req_b[k*SD +: SD] = int_to_fp32(b_int[k]);
        end
        i_req_sub = sub_v;
        #1;
        exp_rdy = predict(vld);
        total++;
        if (o_req_ready !== exp_rdy) begin
            bad++;
            $display("FAIL grant cyc=%0d valid=%b got ready=%b want %b", cyc, vld, o_req_ready, exp_rdy);
        end
        if (exp_rdy != '0) begin
            w = 0;
            for (int k = 0; k < N; k++) if (exp_rdy[k]) w = k;
            it.id  = w;
            it.a   = int_to_fp32(a_int[w]);
            it.b   = int_to_fp32(b_int[w]);
            it.sub = sub_v[w];
            it.res = int_to_fp32(sub_v[w] ? a_int[w] - b_int[w] : a_int[w] + b_int[w]);
            it.ov  = ov_rule(a_int[w]);
            it.cyc = cyc;
            issue_q.push_back(it);
            rsp_q.push_back(it);
            ptr_m = (w + 1) % N;
        end
        prev_en = en;
        @(negedge clk);
    endtask

    // Asynchronous reset away from the clock edge; outputs checked before any edge.
    task automatic do_reset();
        #2;
        rst_n       = 1'b0;
        i_en        = 1'b0;
        i_req_valid = '0;
        #1;
        total++;
        if (o_req_ready !== '0 || o_fpu_valid !== 1'b0 || o_fpu_a !== '0 || o_fpu_b !== '0 ||
            o_fpu_sub !== 1'b0 || o_rsp_valid !== '0 || o_rsp_data !== '0 ||
            o_rsp_ov_flow !== 1'b0 || o_idle !== 1'b1) begin
            bad++;
            $display("FAIL reset_outputs rdy=%b fv=%b a=%h b=%h sub=%b rv=%b rd=%h ov=%b idle=%b want all 0 idle=1",
                     o_req_ready, o_fpu_valid, o_fpu_a, o_fpu_b, o_fpu_sub, o_rsp_valid,
                     o_rsp_data, o_rsp_ov_flow, o_idle);
        end
        issue_q.delete();
        rsp_q.delete();
        prev_en = 1'b0;
        ptr_m   = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic randomize_ops();
        for (int k = 0; k < N; k++) begin
            a_int[k] = int'($urandom_range(0, 255));
            b_int[k] = int'($urandom_range(0, 255));
        end
        sub_v = N'($urandom_range(0, 15));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c_last;
        int last_rsp;
        int idle_cyc;
        rst_n       = 1'b0;
        i_en        = 1'b0;
        i_req_valid = '0;
        i_req_a     = '0;
        i_req_b     = '0;
        i_req_sub   = '0;
        prev_en     = 1'b0;
        ptr_m       = 0;
        for (int k = 0; k < N; k++) begin a_int[k] = k + 1; b_int[k] = 1; end
        sub_v = '0;
        @(negedge clk);
        do_reset();

        // Single op: req1 computes 1.0 + 2.0.
        a_int[1] = 1; b_int[1] = 2; sub_v = '0;
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0010);
        for (int i = 0; i < L + 4; i++) step(1'b1, 4'b0000);

        // Round-robin from pointer 0 with all four requesting.
        do_reset();
        randomize_ops();
        step(1'b1, 4'b0000);
        for (int i = 0; i < 8; i++) step(1'b1, 4'b1111);
        for (int i = 0; i < L + 3; i++) step(1'b1, 4'b0000);

        // Overflow flag only on the op from req2.
        a_int[0] = 1; a_int[1] = 2; a_int[2] = 10; a_int[3] = 3;
        for (int i = 0; i < 4; i++) step(1'b1, 4'b1111);
        for (int i = 0; i < L + 3; i++) step(1'b1, 4'b0000);

        // Drain: third op granted in the same cycle i_en falls.
        randomize_ops();
        step(1'b1, 4'b0001);
        step(1'b1, 4'b0010);
        c_last = cyc;
        step(1'b0, 4'b0100);
        last_rsp = -1;
        idle_cyc = -1;
        for (int i = 0; i < 20 && idle_cyc < 0; i++) begin
            if (o_rsp_valid != '0) last_rsp = cyc;
            if (o_idle && idle_cyc < 0) idle_cyc = cyc;
            step(1'b0, 4'b1111);
        end
        total++;
        if (last_rsp != c_last + L + 2) begin
            bad++;
            $display("FAIL drain_last_rsp got cyc %0d want %0d", last_rsp, c_last + L + 2);
        end
        total++;
        if (idle_cyc < 0 || idle_cyc != last_rsp + 1) begin
            bad++;
            $display("FAIL drain_idle got cyc %0d want %0d", idle_cyc, last_rsp + 1);
        end

        // Sparse wrap: pointer now 3, requests 0 and 2 -> 0, 2, 0.
        step(1'b1, 4'b0000);
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0101);
        for (int i = 0; i < L + 3; i++) step(1'b1, 4'b0000);

        // Random traffic with occasional i_en drops.
        for (int i = 0; i < 300; i++) begin
            randomize_ops();
            step(($urandom_range(0, 15) != 0), N'($urandom_range(0, 15)));
        end

        // Reset with operations in flight; stale FPU results must be ignored.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (o_idle !== 1'b1) begin
                bad++;
                $display("FAIL idle_after_reset cyc=%0d got %b want 1", cyc, o_idle);
            end
            step(1'b0, 4'b1111);
        end

        for (int i = 0; i < 200; i++) begin
            randomize_ops();
            step(($urandom_range(0, 7) != 0), N'($urandom_range(0, 15)));
        end
        for (int i = 0; i < L + 6; i++) step(1'b0, 4'b0000);

        total++;
        if (issue_q.size() != 0 || rsp_q.size() != 0 || o_idle !== 1'b1) begin
            bad++;
            $display("FAIL final_empty got issue_q=%0d rsp_q=%0d idle=%b want 0 0 1",
                     issue_q.size(), rsp_q.size(), o_idle);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
